// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: ALU control word, 64-bit data word,
// and the per-entry operand/entry records held in the issue queue.
package alu_reservation_station_pkg;

  localparam int RS_DEPTH = 4;
  localparam int RS_TAG_W = 4;

  typedef logic [63:0] MemoryWord;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SLT = 4'd8
  } aluop_e;

  typedef struct packed {
    aluop_e aluop;
    logic   usign;
  } control_bits;

  typedef struct packed {
    logic                rdy;
    logic [RS_TAG_W-1:0] tag;
    MemoryWord           val;
  } rs_operand_t;

  typedef struct packed {
    logic                valid;
    control_bits         ctrl;
    logic [RS_TAG_W-1:0] dest;
    rs_operand_t         a;
    rs_operand_t         b;
  } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, result-broadcast and issue signals between dispatch/CDB/ALU and the reservation station.
interface alu_reservation_station_if
  import alu_reservation_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int TAG_W = RS_TAG_W
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  control_bits      disp_ctrl;
  logic [TAG_W-1:0] disp_dest_tag;
  logic             disp_a_rdy;
  logic [TAG_W-1:0] disp_a_tag;
  MemoryWord        disp_a_val;
  logic             disp_b_rdy;
  logic [TAG_W-1:0] disp_b_tag;
  MemoryWord        disp_b_val;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  MemoryWord        cdb_value;
  logic             iss_valid;
  logic             iss_ready;
  control_bits      iss_ctrl;
  MemoryWord        iss_sourceA;
  MemoryWord        iss_sourceB;
  logic [TAG_W-1:0] iss_dest_tag;
  logic [CW-1:0]    count;

  modport slave (
    input  flush, disp_valid, disp_ctrl, disp_dest_tag,
           disp_a_rdy, disp_a_tag, disp_a_val, disp_b_rdy, disp_b_tag, disp_b_val,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    output disp_ready, iss_valid, iss_ctrl, iss_sourceA, iss_sourceB, iss_dest_tag, count
  );

  modport master (
    output flush, disp_valid, disp_ctrl, disp_dest_tag,
           disp_a_rdy, disp_a_tag, disp_a_val, disp_b_rdy, disp_b_tag, disp_b_val,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    input  disp_ready, iss_valid, iss_ctrl, iss_sourceA, iss_sourceB, iss_dest_tag, count
  );

endinterface

// File: rtl/alu_reservation_station_wakeup.sv
// Combinational CDB tag match for one operand: a waiting operand whose producer tag is
// broadcast captures the value and becomes ready.
module rs_operand_wakeup
  import alu_reservation_station_pkg::*;
(
  input  rs_operand_t         op_i,
  input  logic                cdb_valid_i,
  input  logic [RS_TAG_W-1:0] cdb_tag_i,
  input  MemoryWord           cdb_value_i,
  output rs_operand_t         op_o
);

  always_comb begin
    op_o = op_i;
    if (cdb_valid_i && !op_i.rdy && (op_i.tag == cdb_tag_i)) begin
      op_o.rdy = 1'b1;
      op_o.val = cdb_value_i;
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Collapsing-queue reservation station in front of the integer ALU: slot 0 is the oldest entry,
// operands wake up from the CDB and the oldest fully-ready entry is offered to the ALU.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int TAG_W = RS_TAG_W
)
(
  input logic                      clk,
  input logic                      reset,
  alu_reservation_station_if.slave rs
);

  localparam int CW = $clog2(DEPTH + 1);

  rs_entry_t        ent_q [DEPTH];
  rs_entry_t        ent_d [DEPTH];
  rs_entry_t        nxt   [DEPTH+1];
  rs_operand_t      woke_a [DEPTH];
  rs_operand_t      woke_b [DEPTH];
  rs_operand_t      disp_a, disp_b, disp_a_w, disp_b_w;
  rs_entry_t        disp_e;
  logic [CW-1:0]    count_q, count_d, wr_slot;
  logic [DEPTH-1:0] shift_mask;
  logic [TAG_W-1:0] cdb_tag;
  logic             iss_valid, issue, disp_ready, disp_fire;
  control_bits      iss_ctrl;
  MemoryWord        iss_a, iss_b;
  logic [TAG_W-1:0] iss_dest;

  assign cdb_tag = rs.cdb_tag;

  for (genvar i = 0; i < DEPTH; i++) begin : g_wake
    rs_operand_wakeup u_wake_a (
      .op_i(ent_q[i].a), .cdb_valid_i(rs.cdb_valid), .cdb_tag_i(cdb_tag),
      .cdb_value_i(rs.cdb_value), .op_o(woke_a[i])
    );
    rs_operand_wakeup u_wake_b (
      .op_i(ent_q[i].b), .cdb_valid_i(rs.cdb_valid), .cdb_tag_i(cdb_tag),
      .cdb_value_i(rs.cdb_value), .op_o(woke_b[i])
    );
  end

  always_comb begin
    disp_a     = '0;
    disp_a.rdy = rs.disp_a_rdy;
    disp_a.tag = rs.disp_a_tag;
    disp_a.val = rs.disp_a_val;
    disp_b     = '0;
    disp_b.rdy = rs.disp_b_rdy;
    disp_b.tag = rs.disp_b_tag;
    disp_b.val = rs.disp_b_val;
  end

  // An operand arriving with the very tag being broadcast this cycle must not miss it.
  rs_operand_wakeup u_bypass_a (
    .op_i(disp_a), .cdb_valid_i(rs.cdb_valid), .cdb_tag_i(cdb_tag),
    .cdb_value_i(rs.cdb_value), .op_o(disp_a_w)
  );
  rs_operand_wakeup u_bypass_b (
    .op_i(disp_b), .cdb_valid_i(rs.cdb_valid), .cdb_tag_i(cdb_tag),
    .cdb_value_i(rs.cdb_value), .op_o(disp_b_w)
  );

  // Oldest-ready select; shift_mask marks the chosen slot and everything younger.
  always_comb begin
    iss_valid  = 1'b0;
    iss_ctrl   = '0;
    iss_a      = '0;
    iss_b      = '0;
    iss_dest   = '0;
    shift_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!iss_valid && ent_q[i].valid && ent_q[i].a.rdy && ent_q[i].b.rdy) begin
        iss_valid = 1'b1;
        iss_ctrl  = ent_q[i].ctrl;
        iss_a     = ent_q[i].a.val;
        iss_b     = ent_q[i].b.val;
        iss_dest  = ent_q[i].dest;
      end
      shift_mask[i] = iss_valid;
    end
  end

  assign disp_ready = (count_q < CW'(DEPTH));
  assign disp_fire  = rs.disp_valid && disp_ready;
  assign issue      = iss_valid && rs.iss_ready;
  assign wr_slot    = count_q - CW'(issue);

  always_comb begin
    disp_e       = '0;
    disp_e.valid = 1'b1;
    disp_e.ctrl  = rs.disp_ctrl;
    disp_e.dest  = rs.disp_dest_tag;
    disp_e.a     = disp_a_w;
    disp_e.b     = disp_b_w;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i]   = ent_q[i];
      nxt[i].a = woke_a[i];
      nxt[i].b = woke_b[i];
    end
    nxt[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issue && shift_mask[i]) ? nxt[i+1] : nxt[i];
    end
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_slot) ent_d[i] = disp_e;
      end
    end
    if (rs.flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q + CW'(disp_fire) - CW'(issue);
    if (rs.flush) count_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign rs.disp_ready   = disp_ready;
  assign rs.iss_valid    = iss_valid;
  assign rs.iss_ctrl     = iss_ctrl;
  assign rs.iss_sourceA  = iss_a;
  assign rs.iss_sourceB  = iss_b;
  assign rs.iss_dest_tag = iss_dest;
  assign rs.count        = count_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for the ALU reservation station with a queue-based issue scoreboard.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  typedef struct packed {
    control_bits ctrl;
    MemoryWord   a;
    MemoryWord   b;
    logic [3:0]  dest;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mon_got;

  always #5 clk = ~clk;

  alu_reservation_station_if #(.DEPTH(4), .TAG_W(4)) rs ();

  alu_reservation_station #(.DEPTH(4), .TAG_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .rs   (rs)
  );

  function automatic exp_t mk(input aluop_e op, input MemoryWord a, input MemoryWord b,
                              input logic [3:0] dest);
    exp_t e;
    e.ctrl.aluop = op;
    e.ctrl.usign = 1'b0;
    e.a    = a;
    e.b    = b;
    e.dest = dest;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input aluop_e op, input logic [3:0] dest,
                      input logic ar, input logic [3:0] at, input MemoryWord av,
                      input logic br, input MemoryWord bv);
    rs.disp_valid      = 1'b1;
    rs.disp_ctrl.aluop = op;
    rs.disp_ctrl.usign = 1'b0;
    rs.disp_dest_tag   = dest;
    rs.disp_a_rdy      = ar;
    rs.disp_a_tag      = at;
    rs.disp_a_val      = ar ? av : 64'h0;
    rs.disp_b_rdy      = br;
    rs.disp_b_tag      = 4'h0;
    rs.disp_b_val      = bv;
  endtask

  task automatic cdb(input logic [3:0] t, input MemoryWord v);
    rs.cdb_valid = 1'b1;
    rs.cdb_tag   = t;
    rs.cdb_value = v;
  endtask

  // Scoreboard monitor: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && rs.iss_valid && rs.iss_ready) begin
      checks++;
      mon_got = {rs.iss_ctrl, rs.iss_sourceA, rs.iss_sourceB, rs.iss_dest_tag};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got dest=%0h a=%0h b=%0h, required no issue",
                 rs.iss_dest_tag, rs.iss_sourceA, rs.iss_sourceB);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_got !== mon_e) begin
          errors++;
          $display("FAIL issue_data: got ctrl=%0h a=%0h b=%0h dest=%0h required ctrl=%0h a=%0h b=%0h dest=%0h",
                   mon_got.ctrl, mon_got.a, mon_got.b, mon_got.dest,
                   mon_e.ctrl, mon_e.a, mon_e.b, mon_e.dest);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rs.flush = 1'b0; rs.disp_valid = 1'b0; rs.disp_ctrl = '0; rs.disp_dest_tag = '0;
    rs.disp_a_rdy = 1'b0; rs.disp_a_tag = '0; rs.disp_a_val = '0;
    rs.disp_b_rdy = 1'b0; rs.disp_b_tag = '0; rs.disp_b_val = '0;
    rs.cdb_valid = 1'b0; rs.cdb_tag = '0; rs.cdb_value = '0; rs.iss_ready = 1'b1;

    repeat (3) tick();
    chk("reset_count", 64'(rs.count), 64'd0);
    chk("reset_disp_ready", 64'(rs.disp_ready), 64'd1);
    chk("reset_iss_valid", 64'(rs.iss_valid), 64'd0);
    chk("reset_iss_srcA", rs.iss_sourceA, 64'd0);
    reset = 1'b0;
    tick();

    // Ready dispatch issues the next cycle
    exp_q.push_back(mk(ALU_ADD, 64'd5, 64'd7, 4'd1));
    disp(ALU_ADD, 4'd1, 1'b1, 4'd0, 64'd5, 1'b1, 64'd7);
    tick();
    rs.disp_valid = 1'b0;
    chk("ready_count1", 64'(rs.count), 64'd1);
    chk("ready_iss_valid", 64'(rs.iss_valid), 64'd1);
    tick();
    chk("ready_count0", 64'(rs.count), 64'd0);

    // Wakeup from CDB
    disp(ALU_ADD, 4'd4, 1'b0, 4'd3, 64'd0, 1'b1, 64'd2);
    tick();
    rs.disp_valid = 1'b0;
    chk("wake_wait_count", 64'(rs.count), 64'd1);
    chk("wake_wait_valid", 64'(rs.iss_valid), 64'd0);
    tick();
    chk("wake_wait_valid2", 64'(rs.iss_valid), 64'd0);
    exp_q.push_back(mk(ALU_ADD, 64'h10, 64'd2, 4'd4));
    cdb(4'd3, 64'h10);
    tick();
    rs.cdb_valid = 1'b0;
    chk("wake_iss_valid", 64'(rs.iss_valid), 64'd1);
    chk("wake_srcA", rs.iss_sourceA, 64'h10);
    tick();
    chk("wake_count0", 64'(rs.count), 64'd0);

    // Same-cycle dispatch bypass
    exp_q.push_back(mk(ALU_XOR, 64'hFF, 64'd3, 4'd5));
    disp(ALU_XOR, 4'd5, 1'b0, 4'd2, 64'd0, 1'b1, 64'd3);
    cdb(4'd2, 64'hFF);
    tick();
    rs.disp_valid = 1'b0; rs.cdb_valid = 1'b0;
    chk("bypass_iss_valid", 64'(rs.iss_valid), 64'd1);
    chk("bypass_srcA", rs.iss_sourceA, 64'hFF);
    tick();
    chk("bypass_count0", 64'(rs.count), 64'd0);

    // Full and age ordering
    rs.iss_ready = 1'b0;
    disp(ALU_ADD, 4'd8,  1'b0, 4'd6,  64'd0, 1'b1, 64'h208); tick();
    disp(ALU_SUB, 4'd9,  1'b0, 4'd7,  64'd0, 1'b1, 64'h209); tick();
    disp(ALU_AND, 4'd10, 1'b0, 4'd10, 64'd0, 1'b1, 64'h20A); tick();
    disp(ALU_OR,  4'd11, 1'b0, 4'd11, 64'd0, 1'b1, 64'h20B); tick();
    chk("full_count", 64'(rs.count), 64'd4);
    chk("full_disp_ready", 64'(rs.disp_ready), 64'd0);
    disp(ALU_ADD, 4'd15, 1'b1, 4'd0, 64'd1, 1'b1, 64'd1);
    tick();
    rs.disp_valid = 1'b0;
    chk("full_ignored", 64'(rs.count), 64'd4);
    cdb(4'd10, 64'hA2); tick();
    chk("sel_only_slot2", 64'(rs.iss_dest_tag), 64'd10);
    cdb(4'd6, 64'hA0); tick();
    rs.cdb_valid = 1'b0;
    chk("sel_oldest_dest", 64'(rs.iss_dest_tag), 64'd8);
    chk("sel_oldest_srcA", rs.iss_sourceA, 64'hA0);
    exp_q.push_back(mk(ALU_ADD, 64'hA0, 64'h208, 4'd8));
    exp_q.push_back(mk(ALU_AND, 64'hA2, 64'h20A, 4'd10));
    rs.iss_ready = 1'b1;
    tick(); tick();
    rs.iss_ready = 1'b0;
    chk("order_count2", 64'(rs.count), 64'd2);
    disp(ALU_XOR, 4'd12, 1'b0, 4'd12, 64'd0, 1'b1, 64'h20C); tick();
    rs.disp_valid = 1'b0;
    chk("order_count3", 64'(rs.count), 64'd3);
    cdb(4'd7, 64'hA1); tick();
    rs.cdb_valid = 1'b0;
    chk("slot0_sel_dest", 64'(rs.iss_dest_tag), 64'd9);
    exp_q.push_back(mk(ALU_SUB, 64'hA1, 64'h209, 4'd9));
    rs.iss_ready = 1'b1;
    disp(ALU_SLL, 4'd13, 1'b0, 4'd13, 64'd0, 1'b1, 64'h20D);
    tick();
    rs.disp_valid = 1'b0; rs.iss_ready = 1'b0;
    chk("iss_disp_count3", 64'(rs.count), 64'd3);
    chk("iss_disp_none_ready", 64'(rs.iss_valid), 64'd0);
    cdb(4'd13, 64'hB5); tick();
    cdb(4'd11, 64'hB3); tick();
    chk("age_kept_dest", 64'(rs.iss_dest_tag), 64'd11);
    cdb(4'd12, 64'hB4); tick();
    rs.cdb_valid = 1'b0;
    exp_q.push_back(mk(ALU_OR,  64'hB3, 64'h20B, 4'd11));
    exp_q.push_back(mk(ALU_XOR, 64'hB4, 64'h20C, 4'd12));
    exp_q.push_back(mk(ALU_SLL, 64'hB5, 64'h20D, 4'd13));
    rs.iss_ready = 1'b1;
    repeat (3) tick();
    chk("drain_count0", 64'(rs.count), 64'd0);

    // Stall with iss_ready low
    rs.iss_ready = 1'b0;
    disp(ALU_SUB, 4'd6, 1'b1, 4'd0, 64'd100, 1'b1, 64'd30);
    tick();
    rs.disp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", 64'(rs.iss_valid), 64'd1);
      chk("stall_count", 64'(rs.count), 64'd1);
      tick();
    end
    exp_q.push_back(mk(ALU_SUB, 64'd100, 64'd30, 4'd6));
    rs.iss_ready = 1'b1;
    tick();
    chk("stall_release_count", 64'(rs.count), 64'd0);

    // Flush overrides a same-cycle dispatch
    disp(ALU_ADD, 4'd2, 1'b0, 4'd14, 64'd0, 1'b1, 64'd1); tick();
    disp(ALU_ADD, 4'd3, 1'b0, 4'd15, 64'd0, 1'b1, 64'd1); tick();
    chk("preflush_count", 64'(rs.count), 64'd2);
    disp(ALU_ADD, 4'd4, 1'b1, 4'd0, 64'd9, 1'b1, 64'd9);
    rs.flush = 1'b1;
    tick();
    rs.flush = 1'b0; rs.disp_valid = 1'b0;
    chk("flush_count", 64'(rs.count), 64'd0);
    chk("flush_iss_valid", 64'(rs.iss_valid), 64'd0);
    chk("flush_disp_ready", 64'(rs.disp_ready), 64'd1);
    cdb(4'd14, 64'h77); tick();
    rs.cdb_valid = 1'b0;
    chk("flush_stays_empty", 64'(rs.iss_valid), 64'd0);

    // Asynchronous reset in the middle of a fill
    rs.iss_ready = 1'b0;
    disp(ALU_ADD, 4'd7, 1'b0, 4'd5, 64'd0, 1'b1, 64'd1); tick();
    disp(ALU_ADD, 4'd8, 1'b0, 4'd5, 64'd0, 1'b1, 64'd1); tick();
    rs.disp_valid = 1'b0;
    chk("prereset_count", 64'(rs.count), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_count", 64'(rs.count), 64'd0);
    chk("async_reset_disp_ready", 64'(rs.disp_ready), 64'd1);
    tick();
    reset = 1'b0;
    rs.iss_ready = 1'b1;
    tick();
    chk("post_reset_count", 64'(rs.count), 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
